// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// decode_pkg : opcode, ALU, immediate-select and result-select encodings,
//              plus the ID/EX control bundle for the decode stage.
// Revision   : 1.0
// ============================================================================
package decode_pkg;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_src_e;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef struct packed {
    logic       regwrite;
    logic       alusrc;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic [1:0] resultsrc;
    logic [3:0] alucontrol;
    logic       illegal;
  } idex_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/regfile_bypass.sv
`default_nettype none
// ============================================================================
// regfile_bypass : NREG x XLEN register file, two combinational read ports,
//                  one synchronous write port with write-through bypass.
// Revision       : 1.0
// ============================================================================
module regfile_bypass #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int RW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [RW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic [RW-1:0]   ra1,
  input  logic [RW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] r_mem [NREG];

  // Storage is deliberately unreset; x0 is masked on the read side.
  always_ff @(posedge clk) begin
    if (we && (wa != '0)) r_mem[wa] <= wd;
  end

  always_comb begin
    rd1 = '0;
    if (ra1 != '0) rd1 = (we && (wa == ra1)) ? wd : r_mem[ra1];
  end

  always_comb begin
    rd2 = '0;
    if (ra2 != '0) rd2 = (we && (wa == ra2)) ? wd : r_mem[ra2];
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage_hz.sv
`default_nettype none
// ============================================================================
// decode_stage_hz : RISC-V decode stage with bypassed register read, immediate
//                   extension and a stall/flush-controllable ID/EX register.
// Revision        : 1.0
// ============================================================================
module decode_stage_hz
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int RW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCplus4D,
  input  logic            RegwriteW,
  input  logic [RW-1:0]   RDW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            stallE,
  input  logic            flushE,
  output logic            RegwriteE,
  output logic            ALUsrcE,
  output logic            MemwriteE,
  output logic            BranchE,
  output logic            JumpE,
  output logic [1:0]      ResultsrcE,
  output logic [3:0]      ALUcontrolE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmextE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCplus4E,
  output logic [RW-1:0]   RdE,
  output logic [RW-1:0]   RS1E,
  output logic [RW-1:0]   RS2E,
  output logic            validE,
  output logic            illegalE
);

  function automatic logic [3:0] alu_decode(input logic [31:0] instr);
    logic [3:0] a;
    a = ALU_ADD;
    if (instr[6:0] == OP_BEQ) a = ALU_SUB;
    else if (instr[6:0] == OP_RTYPE || instr[6:0] == OP_IALU) begin
      case (instr[14:12])
        3'b000:  a = (instr[5] && instr[30]) ? ALU_SUB : ALU_ADD;
        3'b001:  a = ALU_SLL;
        3'b010:  a = ALU_SLT;
        3'b011:  a = ALU_SLTU;
        3'b100:  a = ALU_XOR;
        3'b101:  a = instr[30] ? ALU_SRA : ALU_SRL;
        3'b110:  a = ALU_OR;
        default: a = ALU_AND;
      endcase
    end
    return a;
  endfunction

  function automatic idex_ctrl_t ctrl_decode(input logic [31:0] instr);
    idex_ctrl_t c;
    c = '0;
    case (instr[6:0])
      OP_LW:    begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.resultsrc = RES_MEM; end
      OP_SW:    begin c.memwrite = 1'b1; c.alusrc = 1'b1; end
      OP_RTYPE: c.regwrite = 1'b1;
      OP_IALU:  begin c.regwrite = 1'b1; c.alusrc = 1'b1; end
      OP_BEQ:   c.branch = 1'b1;
      OP_JAL:   begin c.jump = 1'b1; c.regwrite = 1'b1; c.resultsrc = RES_PC4; end
      OP_LUI:   begin c.regwrite = 1'b1; c.alusrc = 1'b1; end
      default:  c.illegal = 1'b1;
    endcase
    c.alucontrol = alu_decode(instr);
    return c;
  endfunction

  function automatic imm_src_e imm_select(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      OP_LUI:  return IMM_U;
      default: return IMM_I;
    endcase
  endfunction

  // Every format is assembled as a 32-bit value whose MSB is instr[31],
  // so one signed widening covers both XLEN choices.
  function automatic logic [XLEN-1:0] imm_ext(input logic [31:0] instr, input imm_src_e src);
    logic [31:0] w;
    case (src)
      IMM_S:   w = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   w = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   w = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:   w = {instr[31:12], 12'b0};
      default: w = {{20{instr[31]}}, instr[31:20]};
    endcase
    return XLEN'(signed'(w));
  endfunction

  idex_ctrl_t      w_ctrl;
  logic [RW-1:0]   w_rs1;
  logic [RW-1:0]   w_rs2;
  logic [RW-1:0]   w_rd;
  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;
  logic [XLEN-1:0] w_imm;

  assign w_ctrl = ctrl_decode(instrD);
  assign w_rs1  = (instrD[6:0] == OP_LUI) ? '0 : instrD[15 +: RW];
  assign w_rs2  = instrD[20 +: RW];
  assign w_rd   = instrD[7 +: RW];
  assign w_imm  = imm_ext(instrD, imm_select(instrD[6:0]));

  regfile_bypass #(.XLEN(XLEN), .NREG(NREG), .RW(RW)) u_rf (
    .clk (clk),
    .we  (RegwriteW),
    .wa  (RDW),
    .wd  (ResultW),
    .ra1 (w_rs1),
    .ra2 (w_rs2),
    .rd1 (w_rd1),
    .rd2 (w_rd2)
  );

  idex_ctrl_t      r_ctrl;
  logic            r_valid;
  logic [XLEN-1:0] r_rd1, r_rd2, r_imm, r_pc, r_pc4;
  logic [RW-1:0]   r_rd, r_rs1, r_rs2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || flushE) begin
      r_ctrl  <= '0;
      r_valid <= 1'b0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_imm   <= '0;
      r_pc    <= '0;
      r_pc4   <= '0;
      r_rd    <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
    end else if (!stallE) begin
      r_ctrl  <= w_ctrl;
      r_valid <= 1'b1;
      r_rd1   <= w_rd1;
      r_rd2   <= w_rd2;
      r_imm   <= w_imm;
      r_pc    <= PCD;
      r_pc4   <= PCplus4D;
      r_rd    <= w_rd;
      r_rs1   <= w_rs1;
      r_rs2   <= w_rs2;
    end
  end

  assign RegwriteE   = r_ctrl.regwrite;
  assign ALUsrcE     = r_ctrl.alusrc;
  assign MemwriteE   = r_ctrl.memwrite;
  assign BranchE     = r_ctrl.branch;
  assign JumpE       = r_ctrl.jump;
  assign ResultsrcE  = r_ctrl.resultsrc;
  assign ALUcontrolE = r_ctrl.alucontrol;
  assign illegalE    = r_ctrl.illegal;
  assign validE      = r_valid;
  assign RD1E        = r_rd1;
  assign RD2E        = r_rd2;
  assign ImmextE     = r_imm;
  assign PCE         = r_pc;
  assign PCplus4E    = r_pc4;
  assign RdE         = r_rd;
  assign RS1E        = r_rs1;
  assign RS2E        = r_rs2;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_hz.sv
`default_nettype none
// ============================================================================
// tb_decode_stage_hz : directed checks of decode_stage_hz at XLEN 32 and 64.
// Revision           : 1.0
// ============================================================================
module tb_decode_stage_hz;

  logic        clk, rst;
  logic [31:0] instrD, PCD, PCplus4D, ResultW;
  logic        RegwriteW, stallE, flushE;
  logic [4:0]  RDW;

  logic        RegwriteE, ALUsrcE, MemwriteE, BranchE, JumpE, validE, illegalE;
  logic [1:0]  ResultsrcE;
  logic [3:0]  ALUcontrolE;
  logic [31:0] RD1E, RD2E, ImmextE, PCE, PCplus4E;
  logic [4:0]  RdE, RS1E, RS2E;

  logic        q_RegwriteE, q_ALUsrcE, q_MemwriteE, q_BranchE, q_JumpE, q_validE, q_illegalE;
  logic [1:0]  q_ResultsrcE;
  logic [3:0]  q_ALUcontrolE;
  logic [63:0] q_RD1E, q_RD2E, q_ImmextE, q_PCE, q_PCplus4E;
  logic [4:0]  q_RdE, q_RS1E, q_RS2E;

  int n_pass = 0;
  int n_total = 0;

  decode_stage_hz #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst(rst), .instrD(instrD), .PCD(PCD), .PCplus4D(PCplus4D),
    .RegwriteW(RegwriteW), .RDW(RDW), .ResultW(ResultW),
    .stallE(stallE), .flushE(flushE),
    .RegwriteE(RegwriteE), .ALUsrcE(ALUsrcE), .MemwriteE(MemwriteE),
    .BranchE(BranchE), .JumpE(JumpE), .ResultsrcE(ResultsrcE),
    .ALUcontrolE(ALUcontrolE), .RD1E(RD1E), .RD2E(RD2E), .ImmextE(ImmextE),
    .PCE(PCE), .PCplus4E(PCplus4E), .RdE(RdE), .RS1E(RS1E), .RS2E(RS2E),
    .validE(validE), .illegalE(illegalE)
  );

  decode_stage_hz #(.XLEN(64), .NREG(32)) dut64 (
    .clk(clk), .rst(rst), .instrD(instrD), .PCD({32'b0, PCD}),
    .PCplus4D({32'b0, PCplus4D}),
    .RegwriteW(RegwriteW), .RDW(RDW), .ResultW({32'b0, ResultW}),
    .stallE(stallE), .flushE(flushE),
    .RegwriteE(q_RegwriteE), .ALUsrcE(q_ALUsrcE), .MemwriteE(q_MemwriteE),
    .BranchE(q_BranchE), .JumpE(q_JumpE), .ResultsrcE(q_ResultsrcE),
    .ALUcontrolE(q_ALUcontrolE), .RD1E(q_RD1E), .RD2E(q_RD2E), .ImmextE(q_ImmextE),
    .PCE(q_PCE), .PCplus4E(q_PCplus4E), .RdE(q_RdE), .RS1E(q_RS1E), .RS2E(q_RS2E),
    .validE(q_validE), .illegalE(q_illegalE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Concatenated control flags: {Regwrite, ALUsrc, Memwrite, Branch, Jump, valid, illegal}
  function automatic logic [6:0] flags32();
    return {RegwriteE, ALUsrcE, MemwriteE, BranchE, JumpE, validE, illegalE};
  endfunction

  function automatic logic [63:0] all_or32();
    return {57'b0, flags32()} | 64'(ResultsrcE) | 64'(ALUcontrolE) | 64'(RD1E) |
           64'(RD2E) | 64'(ImmextE) | 64'(PCE) | 64'(PCplus4E) |
           64'(RdE) | 64'(RS1E) | 64'(RS2E);
  endfunction

  initial begin
    rst = 1'b0; instrD = 32'h0000_0013; PCD = 32'h0; PCplus4D = 32'h4;
    RegwriteW = 1'b0; RDW = 5'd0; ResultW = 32'h0; stallE = 1'b0; flushE = 1'b0;
    step(); step();
    chk("reset_all_zero", all_or32(), 64'h0);
    chk("reset_valid64", {63'b0, q_validE}, 64'h0);

    rst = 1'b1;
    RegwriteW = 1'b1; RDW = 5'd1; ResultW = 32'd9; step();
    RDW = 5'd2; ResultW = 32'd4; step();
    chk("first_load_valid", {63'b0, validE}, 64'h1);

    // sub x2, x1, x2
    RegwriteW = 1'b0; instrD = 32'h4020_8133; step();
    chk("sub_rd1", 64'(RD1E), 64'd9);
    chk("sub_rd2", 64'(RD2E), 64'd4);
    chk("sub_alu", 64'(ALUcontrolE), 64'b0001);
    chk("sub_rd", 64'(RdE), 64'd2);
    chk("sub_flags", 64'(flags32()), 64'b1000010);
    chk("sub_rs", {RS1E, RS2E}, {5'd1, 5'd2});

    // addi x6, x5, 0 with x5 written in the same cycle
    RegwriteW = 1'b1; RDW = 5'd5; ResultW = 32'hABCD; instrD = 32'h0002_8313; step();
    chk("bypass_rd1", 64'(RD1E), 64'hABCD);
    chk("bypass_alusrc", {63'b0, ALUsrcE}, 64'h1);
    RDW = 5'd0; instrD = 32'h0000_0313; step();
    chk("bypass_x0", 64'(RD1E), 64'h0);
    RegwriteW = 1'b0; instrD = 32'h0002_8313; step();
    chk("x5_stored", 64'(RD1E), 64'hABCD);

    // lw x7, 8(x1)
    PCD = 32'h40; PCplus4D = 32'h44; instrD = 32'h0080_A383; step();
    chk("lw_imm", 64'(ImmextE), 64'd8);
    chk("lw_resultsrc", 64'(ResultsrcE), 64'b01);
    chk("lw_flags", 64'(flags32()), 64'b1100010);
    chk("lw_pc", {PCE, PCplus4E}, {32'h40, 32'h44});

    // two stalled cycles with new input and a write to x3
    stallE = 1'b1; instrD = 32'h4020_8133; PCD = 32'h80; PCplus4D = 32'h84;
    RegwriteW = 1'b1; RDW = 5'd3; ResultW = 32'h55; step();
    RegwriteW = 1'b0; step();
    chk("stall_imm", 64'(ImmextE), 64'd8);
    chk("stall_rd_rd1", {RdE, RD1E}, {5'd7, 32'd9});
    chk("stall_ctl", {ResultsrcE, ALUcontrolE, flags32()}, {2'b01, 4'b0000, 7'b1100010});
    chk("stall_pc", 64'(PCE), 64'h40);

    flushE = 1'b1; step();
    chk("flush_all_zero", all_or32(), 64'h0);
    flushE = 1'b0; stallE = 1'b0;

    // jal x1, +2048
    PCD = 32'h100; PCplus4D = 32'h104; instrD = 32'h0010_00EF; step();
    chk("jal_imm", 64'(ImmextE), 64'h800);
    chk("jal_ctl", {ResultsrcE, flags32()}, {2'b10, 7'b1000110});
    chk("jal_pc4", 64'(PCplus4E), 64'h104);

    // lui x3, 0xFFFFF  (rs1 field 31, never written)
    instrD = 32'hFFFF_F1B7; step();
    chk("lui_imm", 64'(ImmextE), 64'hFFFF_F000);
    chk("lui_rs1", {RS1E, RD1E}, 64'h0);
    chk("lui_alu", {ALUcontrolE, flags32()}, {4'b0000, 7'b1100010});
    chk("lui_imm64", q_ImmextE, 64'hFFFF_FFFF_FFFF_F000);

    // add x8, x3, x0 : x3 was written during the stall
    instrD = 32'h0001_8433; step();
    chk("write_in_stall", {RD1E, RD2E}, {32'h55, 32'h0});

    // beq x1, x2, +8
    instrD = 32'h0020_8463; step();
    chk("beq_imm", 64'(ImmextE), 64'd8);
    chk("beq_ctl", {ALUcontrolE, flags32()}, {4'b0001, 7'b0001010});

    // sw x2, -4(x1)
    instrD = 32'hFE20_AE23; step();
    chk("sw_imm", 64'(ImmextE), 64'hFFFF_FFFC);
    chk("sw_flags", 64'(flags32()), 64'b0110010);

    // srai x4, x1, 3
    instrD = 32'h4030_D213; step();
    chk("srai_alu", 64'(ALUcontrolE), 64'b1000);

    instrD = 32'h0000_0000; step();
    chk("illegal_flags", {ResultsrcE, flags32()}, {2'b00, 7'b0000011});

    // addi x1, x0, -1
    instrD = 32'hFFF0_0093; step();
    chk("addi_m1_imm32", 64'(ImmextE), 64'hFFFF_FFFF);
    chk("addi_m1_imm64", q_ImmextE, 64'hFFFF_FFFF_FFFF_FFFF);

    // asynchronous reset in the middle of a stall
    stallE = 1'b1; #2 rst = 1'b0; #1;
    chk("async_rst_now", all_or32(), 64'h0);
    chk("async_rst_64", q_ImmextE | {63'b0, q_validE}, 64'h0);
    step();
    chk("rst_held", all_or32(), 64'h0);
    rst = 1'b1; stallE = 1'b0; instrD = 32'h0080_A383; step();
    chk("post_rst_load", {ImmextE, 25'b0, flags32()}, {32'd8, 25'b0, 7'b1100010});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_stage_hz.md
# decode_stage_hz

Parametrised decode stage for the 5-stage RISC-V pipeline. It decodes the instruction in D, reads the register file with write-through bypass from W, and sign-extends the I/S/B/J/U immediates. It drives a hazard-controllable ID/EX pipeline register with hold (stall) and bubble (flush) support. It sits between the fetch stage's IF/ID register and the execute stage, and takes its stall/flush controls from the hazard unit.

## Interface
Parameters:
- `XLEN`, 32 — datapath width (32 or 64)
- `NREG`, 32 — architectural registers; register index width is `RW = $clog2(NREG)`

Ports:
- `clk` in 1 — the only clock; all state updates on its rising edge
- `rst` in 1 — asynchronous, active-low reset
- `instrD` in 32 — instruction in D
- `PCD`, `PCplus4D` in XLEN — PC and PC+4 of the instruction in D
- `RegwriteW` in 1 — writeback enable
- `RDW` in RW — writeback destination
- `ResultW` in XLEN — writeback data
- `stallE` in 1 — hold ID/EX contents
- `flushE` in 1 — load a bubble into ID/EX
- `RegwriteE`, `ALUsrcE`, `MemwriteE`, `BranchE`, `JumpE` out 1 — registered controls
- `ResultsrcE` out 2 — 00 ALU, 01 memory, 10 PC+4
- `ALUcontrolE` out 4 — ALU operation
- `RD1E`, `RD2E`, `ImmextE`, `PCE`, `PCplus4E` out XLEN — registered data
- `RdE`, `RS1E`, `RS2E` out RW — registered register indices
- `validE` out 1 — E holds a real instruction (0 for a bubble)
- `illegalE` out 1 — unrecognised opcode reached E

## Operation
- **Opcodes decoded:**
  - 0000011 lw: Regwrite, ALUsrc, Resultsrc 01, imm I
  - 0100011 sw: Memwrite, ALUsrc, imm S
  - 0110011 R-type: Regwrite
  - 0010011 I-ALU: Regwrite, ALUsrc, imm I
  - 1100011 beq: Branch, ALU sub, imm B
  - 1101111 jal: Jump, Regwrite, Resultsrc 10, imm J
  - 0110111 lui: Regwrite, ALUsrc, imm U, ALU add. rs1 is forced to index 0 so the operand is 0.
- **ALUcontrol by funct3:**
  - 000: add 0000, or sub 0001 when op[5] and funct7[5] are both set
  - 001: sll 0100
  - 010: slt 0101
  - 011: sltu 1001
  - 100: xor 0110
  - 101: srl 0111, or sra 1000 when funct7[5] is set
  - 110: or 0011
  - 111: and 0010
  - lw, sw, jal and lui use add.
- **Illegal opcode:** all write, memory, branch and jump controls are 0, `illegalE` = 1, `validE` = 1.
- **Immediates:** sign-extended to XLEN from instr[31].
  - U = {instr[31:12], 12'b0}, sign-extended.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- **Register file:**
  - NREG×XLEN, two combinational read ports, one synchronous write port.
  - A write to index 0 is ignored, and reads of index 0 return 0.
  - Write-through bypass: if `RegwriteW`, `RDW` == rs, and rs ≠ 0, the read data is `ResultW` in the same cycle.
- **ID/EX update priority:** `rst` low > `flushE` > `stallE` > load.
  - Flush: all outputs go to 0, including `validE` and `illegalE`.
  - Stall: all outputs hold their value.
  - The register file write still occurs during a stall or flush.

## Timing
- Latency is 1 cycle: the decode of `instrD` at edge N appears on the E outputs after edge N.
- Reset is asynchronous. Every E output is 0 immediately on `rst` low and stays 0 while `rst` is low. The register-file contents are not reset, except that x0 reads 0.
- First load occurs at the first rising edge after `rst` is released.
- `flushE` and `stallE` asserted in the same cycle: the flush wins.
- A register write and a read of the same register in the same cycle returns the new value, with no extra cycle.
- Reset asserted mid-stall clears the held contents. After reset, the block resumes with a normal load.

## Structure
- **Package `decode_pkg`:**
  - opcode constants
  - 4-bit ALU control encodings
  - 3-bit ImmSrc encodings (I, S, B, J, U)
  - ResultSrc encodings
  - ID/EX bundle struct
- **Sub-modules:**
  - `regfile_bypass` (`XLEN`, `NREG`): register file with the write-through bypass.
  - Control decode and immediate extension stay combinational functions inside the top module.

## Test plan
- **Reset:** `rst` low mid-run → all E outputs 0 asynchronously, before the next edge.
- **sub decode:** `instrD` = 0x40208133 (sub x2, x1, x2) with x1 = 9, x2 = 4 → next cycle RD1E = 9, RD2E = 4, ALUcontrolE = 0001, RdE = 2, RegwriteE = 1.
- **Bypass:** RegwriteW = 1, RDW = 5, ResultW = 0xABCD while `instrD` reads rs1 = x5 → next cycle RD1E = 0xABCD. The same stimulus with RDW = 0 → RD1E = old x0 = 0.
- **Stall then flush:** lw in E, `stallE` for 2 cycles → outputs unchanged. Then `flushE` together with `stallE` → all outputs 0 and `validE` = 0.
- **Immediates:** jal x1, +2048 → ImmextE = 0x800, JumpE = 1, ResultsrcE = 10. lui x3, 0xFFFFF → ImmextE = 0xFFFFF000.
- **Illegal and XLEN=64:** opcode 0000000 → `illegalE` = 1 and all write/memory/branch/jump controls 0. Rerun the addi −1 case with XLEN = 64 → ImmextE = 0xFFFFFFFFFFFFFFFF.
